stm32_bus_master: RTL and testbench
===================================

// Module: stm32_bus_master
// PURPOSE
//  Initiator end of the STM32<->FPGA 8-bit parallel link: drives DATA_SYNC plus a command byte, then sequences N data bytes.
//  Each byte is either written onto DATA_BUS or sampled back from the responder, one byte per clk_in cycle.
//  Used in the bench/loopback rig and in FPGA-to-FPGA builds to talk to the transceiver's bus responder.
//  Free-running protocol with no wait states: the responder advances every clock, so this block never stalls mid-transfer.
// PARAMETERS
//  LEN_W     16  width of byte-count field
//  TURN_CYC  1   SYNC-high, bus-released cycles inserted before CMD when the previous transfer was a read (1..3)
// PORTS
//  clk_in       in     1      system clock; all logic on posedge
//  reset        in     1      synchronous, active-high reset
//  cmd_valid    in     1      command request
//  cmd_ready    out    1      high in IDLE; command accepted on cmd_valid&&cmd_ready
//  cmd_code     in     8      command byte placed on bus in CMD cycle
//  cmd_write    in     1      1 = master drives data bytes, 0 = master samples data bytes
//  cmd_len      in     LEN_W  data byte count; 0 = command-only (e.g. reset on/off)
//  wr_data      in     8      next write byte
//  wr_valid     in     1      wr_data valid
//  wr_ready     out    1      byte consumed this cycle if wr_valid
//  wr_underrun  out    1      sticky: a write byte was needed and wr_valid was low; cleared on next cmd accept
//  rd_data      out    8      captured read byte
//  rd_valid     out    1      1-cycle strobe per read byte, no backpressure
//  rd_last      out    1      with rd_valid on final byte
//  abort        in     1      terminate current transfer
//  busy         out    1      high in any state except IDLE
//  DATA_SYNC    out    1      frame-start strobe to responder
//  DATA_BUS     inout  8      driven only while bus_oe=1, else 8'bZ
// BEHAVIOUR
//  Reset: DATA_SYNC=0, bus_oe=0, bus_out=0, rd_data=0, rd_valid=0, rd_last=0, wr_ready=0, wr_underrun=0, busy=0, cmd_ready=1 (after reset), last_was_read=1.
//  All bus outputs are registered. Tn = nth cycle of registered outputs after CMD.
//  States: IDLE -> (last_was_read ? TURN : CMD); TURN -> CMD after TURN_CYC cycles.
//  From CMD: len==0 -> DONE; write -> WR; read -> RD.  WR/RD -> DONE after cnt==len.  DONE -> IDLE (1 cycle; min 1-cycle gap).
//  Command accept: latch code/len/dir, clear wr_underrun, cnt=0.
//  TURN: DATA_SYNC=1, bus_oe=0. Responder sees a junk command and releases its driver.
//  CMD (T0): DATA_SYNC=1, bus_oe=1, bus_out=cmd_code.
//  WR (T1..Tlen): DATA_SYNC=0, bus_oe=1, bus_out=byte i-1.
//    wr_ready=1 in the cycle before each Ti (i.e., T0..Tlen-1).
//    !wr_valid -> bus_out=8'h00 and wr_underrun=1. last_was_read<=0.
//  RD: DATA_SYNC=0, bus_oe=0 from T1. Byte i is captured from DATA_BUS at the edge ending T(i+2), i=0..len-1.
//    rd_valid=1 in T(i+3); rd_last with byte len-1. RD lasts len+1 cycles (T1..Tlen+1). last_was_read<=1.
//  cnt is LEN_W bits and counts up to len; len=2^LEN_W-1 is legal; no wrap.
//  abort in TURN/CMD/WR/RD: next cycle -> DONE.
//    DATA_SYNC=0 and bus_oe=0 in DONE; in-flight rd capture suppressed (no rd_valid after abort).
//    last_was_read<=1 (responder state unknown).
//  cmd_valid in DONE is ignored (cmd_ready=0); cmd_valid&&abort in IDLE -> command accepted, abort ignored.
//  Reset mid-transfer: outputs to reset values next edge; bus released same edge.
//  Streaming responder modes (RX IQ) are ended simply by len expiry; the responder idles until the next SYNC.
//  Interleaved modes (bus test 0, flash read 7) are not supported as a single transfer.
// TESTING
//  1. After reset, write cmd 1 len 21 bytes 0x01..0x15 -> TURN 1 cycle, SYNC high 2 cycles, bus=0x01 in CMD.
//     T1..T21 = 0x01..0x15; 21 wr_ready; no underrun.
//  2. Read cmd 8 len 3 vs behavioural responder (4,0,0) -> rd_valid in T3,T4,T5 with 4,0,0; rd_last on 0; busy low after DONE.
//  3. Read cmd 2 len 10 then immediately read cmd 4 len 6 -> TURN_CYC SYNC-only cycles before second CMD; no cycle with both drivers enabled.
//  4. Write len 6, wr_valid low for byte 3 -> bus T4=0x00, wr_underrun=1 until next accept; other bytes intact.
//  5. cmd 5 len 0 -> exactly one CMD cycle then DONE; no wr_ready, no rd_valid.
//  6. abort at T2 of read len 12 / reset at T4 -> DONE next cycle, bus_oe=0, SYNC=0, no further rd_valid; next cmd gets TURN.

Source files
------------

// File: rtl/stm32_bus_master.sv
// -----------------------------------------------------------------------------
// stm32_bus_master
// Initiator end of the 8-bit STM32<->FPGA parallel link. A command raises
// DATA_SYNC and puts the command byte on DATA_BUS for one cycle (CMD = T0).
// The block then streams cmd_len data bytes, one per clock with no stalls.
// Each byte is either driven by this block or sampled from the responder.
// After a read, TURN_CYC SYNC-high cycles with the bus released come before the
// next CMD. These give the responder time to drop its driver.
//
// Ports
//   clk_in, reset      clock / synchronous active-high reset
//   cmd_valid/ready    command handshake (ready only in IDLE)
//   cmd_code/write/len command byte, direction (1 = write), data byte count
//   wr_data/valid      write byte stream; wr_ready = byte consumed this cycle
//   wr_underrun        sticky: a write slot found wr_valid low (cleared on accept)
//   rd_data/valid/last captured read byte, 1-cycle strobe, final-byte marker
//   abort              terminate current transfer (goes to DONE next cycle)
//   busy               high in every state except IDLE
//   DATA_SYNC          frame-start strobe to the responder
//   DATA_BUS           bidirectional data bus, driven only while bus_oe_q=1
// -----------------------------------------------------------------------------
module stm32_bus_master #(
  parameter int LEN_W    = 16,
  parameter int TURN_CYC = 1
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_code,
  input  logic             cmd_write,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic             wr_underrun,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             rd_last,
  input  logic             abort,
  output logic             busy,
  output logic             DATA_SYNC,
  inout  wire  [7:0]       DATA_BUS
);

  typedef enum logic [2:0] {
    S_IDLE, S_TURN, S_CMD, S_WR, S_RD, S_DONE
  } state_t;

  localparam logic [1:0] TURN_LAST = 2'(TURN_CYC - 1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       turn_cnt_q, turn_cnt_d;
  logic [7:0]       code_q, code_d;
  logic             write_q, write_d;
  logic             last_was_read_q, last_was_read_d;
  logic             wr_underrun_q, wr_underrun_d;
  logic             sync_q, sync_d;
  logic             bus_oe_q, bus_oe_d;
  logic [7:0]       bus_out_q, bus_out_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_last_q, rd_last_d;
  logic             wr_take;
  logic             rd_capture;

  // A write byte is consumed in the cycle before it appears on the bus:
  // in CMD for byte 0, and in WR while fewer than len bytes have been taken.
  // Aborting cycles consume nothing, so no byte is lost to a cancelled slot.
  assign wr_take = !abort &&
                   (((state_q == S_CMD) && write_q && (len_q != '0)) ||
                    ((state_q == S_WR) && (cnt_q != len_q)));

  // In RD, cnt_q counts the RD cycles already elapsed. The responder's first
  // byte is valid from the second RD cycle (T2), so cnt_q != 0 marks a capture.
  assign rd_capture = (state_q == S_RD) && (cnt_q != '0) && !abort;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      len_q           <= '0;
      turn_cnt_q      <= '0;
      code_q          <= '0;
      write_q         <= 1'b0;
      last_was_read_q <= 1'b1;
      wr_underrun_q   <= 1'b0;
      sync_q          <= 1'b0;
      bus_oe_q        <= 1'b0;
      bus_out_q       <= '0;
      rd_data_q       <= '0;
      rd_valid_q      <= 1'b0;
      rd_last_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      len_q           <= len_d;
      turn_cnt_q      <= turn_cnt_d;
      code_q          <= code_d;
      write_q         <= write_d;
      last_was_read_q <= last_was_read_d;
      wr_underrun_q   <= wr_underrun_d;
      sync_q          <= sync_d;
      bus_oe_q        <= bus_oe_d;
      bus_out_q       <= bus_out_d;
      rd_data_q       <= rd_data_d;
      rd_valid_q      <= rd_valid_d;
      rd_last_q       <= rd_last_d;
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    len_d           = len_q;
    turn_cnt_d      = turn_cnt_q;
    code_d          = code_q;
    write_d         = write_q;
    last_was_read_d = last_was_read_q;
    wr_underrun_d   = wr_underrun_q;

    if (wr_take && !wr_valid) begin
      wr_underrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        // abort is ignored here; a pending command always wins
        if (cmd_valid) begin
          code_d        = cmd_code;
          len_d         = cmd_len;
          write_d       = cmd_write;
          wr_underrun_d = 1'b0;
          cnt_d         = '0;
          turn_cnt_d    = '0;
          state_d       = last_was_read_q ? S_TURN : S_CMD;
        end
      end
      S_TURN: begin
        if (abort) begin
          state_d         = S_DONE;
          last_was_read_d = 1'b1;
        end else if (turn_cnt_q == TURN_LAST) begin
          state_d = S_CMD;
        end else begin
          turn_cnt_d = turn_cnt_q + 2'd1;
        end
      end
      S_CMD: begin
        if (abort) begin
          state_d         = S_DONE;
          last_was_read_d = 1'b1;
        end else if (len_q == '0) begin
          state_d = S_DONE;
        end else if (write_q) begin
          state_d         = S_WR;
          cnt_d           = {{(LEN_W-1){1'b0}}, 1'b1};  // byte 0 taken in CMD
          last_was_read_d = 1'b0;
        end else begin
          state_d         = S_RD;
          cnt_d           = '0;
          last_was_read_d = 1'b1;
        end
      end
      S_WR, S_RD: begin
        // WR spans T1..Tlen, RD spans T1..Tlen+1; both end once cnt hits len,
        // and cnt never increments past len so len = all-ones cannot wrap.
        if (abort) begin
          state_d         = S_DONE;
          last_was_read_d = 1'b1;
        end else if (cnt_q == len_q) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // Bus outputs are computed from the next state so they line up with state_q.
  always_comb begin
    sync_d     = 1'b0;
    bus_oe_d   = 1'b0;
    bus_out_d  = 8'h00;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    rd_data_d  = rd_data_q;

    case (state_d)
      S_TURN: sync_d = 1'b1;
      S_CMD: begin
        sync_d    = 1'b1;
        bus_oe_d  = 1'b1;
        bus_out_d = code_d;
      end
      S_WR: begin
        bus_oe_d  = 1'b1;
        bus_out_d = wr_valid ? wr_data : 8'h00;
      end
      default: ;
    endcase

    if (rd_capture) begin
      rd_valid_d = 1'b1;
      rd_data_d  = DATA_BUS;
      rd_last_d  = (cnt_q == len_q);
    end
  end

  assign DATA_BUS    = bus_oe_q ? bus_out_q : 8'bzzzz_zzzz;
  assign DATA_SYNC   = sync_q;
  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign wr_ready    = wr_take;
  assign wr_underrun = wr_underrun_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign rd_last     = rd_last_q;

endmodule

// File: tb/tb_stm32_bus_master.sv
// -----------------------------------------------------------------------------
// tb_stm32_bus_master
// Directed bench for stm32_bus_master. The stimulus pushes expected bus and
// read events into a scoreboard queue. A negedge monitor pops an entry and
// compares it whenever the DUT shows SYNC, drives the bus or strobes rd_valid.
// A behavioural responder drives read data. It latches the command on the last
// SYNC-high cycle and drives byte i during T(i+2). It keeps streaming until
// the next SYNC, so a missing turnaround appears as bus contention.
// -----------------------------------------------------------------------------
module tb_stm32_bus_master;

  localparam int TURN_CYC = 1;
  localparam int K_TURN = 0, K_CMD = 1, K_WR = 2, K_RD = 3;

  typedef struct {
    int         kind;
    int         t;
    logic [7:0] data;
    logic       last;
  } ev_t;

  typedef struct {
    logic       v;
    logic [7:0] d;
  } feed_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_write, wr_valid, abort;
  logic [7:0]  cmd_code, wr_data;
  logic [15:0] cmd_len;
  wire         cmd_ready, wr_ready, wr_underrun, rd_valid, rd_last, busy, DATA_SYNC;
  wire  [7:0]  rd_data;
  wire  [7:0]  DATA_BUS;

  logic        resp_oe = 1'b0;
  logic [7:0]  resp_data = 8'h00;
  logic [7:0]  resp_cmd = 8'h00;
  logic        resp_act = 1'b0;
  int          resp_phase = 0;

  ev_t   exp_q[$];
  feed_t feed_q[$];
  feed_t feed_cur;
  int    checks = 0;
  int    errors = 0;
  int    wr_cnt = 0;
  int    t_mon = 0;
  logic  mon_en = 1'b0;
  logic  lwr = 1'b1;   // expected "last transfer was a read" state

  assign DATA_BUS = resp_oe ? resp_data : 8'bzzzz_zzzz;

  always #5 clk = ~clk;

  stm32_bus_master #(.LEN_W(16), .TURN_CYC(TURN_CYC)) dut (
    .clk_in(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code),
    .cmd_write(cmd_write), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_underrun(wr_underrun),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .abort(abort), .busy(busy), .DATA_SYNC(DATA_SYNC), .DATA_BUS(DATA_BUS)
  );

  // Responder read data: cmd 8 answers 4,0,0,...; other even commands answer
  // cmd*16+i. Odd commands are writes and the responder never drives for them.
  function automatic logic [7:0] rbyte(input logic [7:0] c, input int i);
    if (c == 8'd8) return (i == 0) ? 8'd4 : 8'd0;
    return 8'(int'(c) * 16 + i);
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_TURN:  return "TURN";
      K_CMD:   return "CMD";
      K_WR:    return "WR";
      default: return "RD";
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input int t, input logic [7:0] d, input logic last);
    ev_t e;
    e.kind = kind; e.t = t; e.data = d; e.last = last;
    exp_q.push_back(e);
  endtask

  task automatic exp_head(input logic [7:0] code);
    if (lwr) begin
      for (int k = 0; k < TURN_CYC; k++) push_ev(K_TURN, 0, 8'h00, 1'b0);
    end
    push_ev(K_CMD, 0, code, 1'b0);
  endtask

  task automatic exp_read(input logic [7:0] code, input int len);
    exp_head(code);
    for (int i = 0; i < len; i++) push_ev(K_RD, i + 3, rbyte(code, i), i == len - 1);
    if (len > 0) lwr = 1'b1;
  endtask

  // Write bytes base+i; slot 'skip' is offered with wr_valid low (expect 00).
  task automatic do_write(input logic [7:0] code, input int len, input logic [7:0] base, input int skip);
    feed_t f;
    exp_head(code);
    for (int i = 0; i < len; i++) begin
      f.v = (i != skip);
      f.d = f.v ? 8'(int'(base) + i) : 8'hEE;
      feed_q.push_back(f);
      push_ev(K_WR, i + 1, f.v ? f.d : 8'h00, 1'b0);
    end
    if (len > 0) lwr = 1'b0;
  endtask

  task automatic issue(input logic [7:0] code, input logic wr, input int len);
    int n;
    @(negedge clk);
    cmd_code = code; cmd_write = wr; cmd_len = 16'(len); cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd %02h not accepted within 300 cycles", code);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 500);
    if (busy) begin
      checks++; errors++;
      $display("FAIL wait_idle: busy still %0b after %0d cycles, required 0", busy, n);
    end
  endtask

  // Returns at the negedge of T1 (first SYNC-low cycle after SYNC rose).
  task automatic wait_t1();
    int n;
    n = 0;
    while (!DATA_SYNC && n < 50) begin @(negedge clk); n++; end
    while (DATA_SYNC && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL wait_t1: no SYNC pulse within %0d cycles", n);
    end
  endtask

  task automatic check_ev(input int kind, input int t, input logic [7:0] d, input logic last);
    ev_t e;
    logic bad;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got %s t=%0d data=%02h, required none", kname(kind), t, d);
      return;
    end
    e = exp_q.pop_front();
    bad = (e.kind != kind);
    if ((kind == K_WR || kind == K_RD) && e.t != t) bad = 1'b1;
    if (kind != K_TURN && e.data !== d) bad = 1'b1;
    if (kind == K_RD && e.last !== last) bad = 1'b1;
    if (bad) begin
      errors++;
      $display("FAIL bus_event: got %s t=%0d data=%02h last=%0b, required %s t=%0d data=%02h last=%0b",
               kname(kind), t, d, last, kname(e.kind), e.t, e.data, e.last);
    end
  endtask

  // Monitor: classify each cycle's outputs and compare against the scoreboard.
  always @(negedge clk) begin
    if (DATA_SYNC && dut.bus_oe_q) t_mon = 0;
    else if (t_mon < 100000) t_mon++;
    if (mon_en) begin
      if (DATA_SYNC) check_ev(dut.bus_oe_q ? K_CMD : K_TURN, t_mon, DATA_BUS, 1'b0);
      else if (dut.bus_oe_q) check_ev(K_WR, t_mon, DATA_BUS, 1'b0);
      if (rd_valid) check_ev(K_RD, t_mon, rd_data, rd_last);
    end
  end

  // Write-data feeder: offers the next queued slot whenever wr_ready is high.
  always @(negedge clk) begin
    if (wr_ready) begin
      wr_cnt++;
      if (feed_q.size() > 0) begin
        feed_cur = feed_q.pop_front();
        wr_valid = feed_cur.v;
        wr_data  = feed_cur.d;
      end else begin
        wr_valid = 1'b0;
      end
    end else begin
      wr_valid = 1'b0;
      wr_data  = 8'h00;
    end
  end

  // Behavioural responder plus a drive-overlap check on both half cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (resp_oe && dut.bus_oe_q) begin
        errors++;
        $display("FAIL contention_a: master oe %0b responder oe %0b, required not both", dut.bus_oe_q, resp_oe);
      end
    end
    if (DATA_SYNC) begin
      resp_cmd = DATA_BUS; resp_phase = 0; resp_act = 1'b1; resp_oe = 1'b0;
    end else if (resp_act) begin
      if (resp_phase < 1000) resp_phase++;
      if (!resp_cmd[0] && resp_phase >= 2) begin
        resp_oe   = 1'b1;
        resp_data = rbyte(resp_cmd, resp_phase - 2);
      end
    end
    if (mon_en) begin
      checks++;
      if (resp_oe && dut.bus_oe_q) begin
        errors++;
        $display("FAIL contention_b: master oe %0b responder oe %0b, required not both", dut.bus_oe_q, resp_oe);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_code = 8'h00;
    cmd_len = 16'h0; abort = 1'b0; wr_valid = 1'b0; wr_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sync", 32'(DATA_SYNC), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_underrun", 32'(wr_underrun), 32'd0);
    chk("reset_wr_ready", 32'(wr_ready), 32'd0);
    $display("reset done");

    // 1: write cmd 1, 21 bytes 0x01..0x15, turnaround first
    wr_cnt = 0;
    do_write(8'h01, 21, 8'h01, -1);
    issue(8'h01, 1'b1, 21);
    wait_idle(n);
    chk("t1_cycles_to_idle", 32'(n), 32'd25);
    chk("t1_wr_ready_count", 32'(wr_cnt), 32'd21);
    chk("t1_underrun", 32'(wr_underrun), 32'd0);
    $display("txn write cmd=01 len=21");

    // 2: read cmd 8 len 3 -> 4,0,0
    exp_read(8'h08, 3);
    issue(8'h08, 1'b0, 3);
    wait_idle(n);
    chk("t2_cycles_to_idle", 32'(n), 32'd7);
    $display("txn read cmd=08 len=3");

    // 3: back-to-back reads, second needs a turnaround
    exp_read(8'h02, 10);
    exp_read(8'h04, 6);
    issue(8'h02, 1'b0, 10);
    issue(8'h04, 1'b0, 6);
    wait_idle(n);
    $display("txn read cmd=02 len=10 then cmd=04 len=6");

    // 4: write len 6 with byte 3 missing
    wr_cnt = 0;
    do_write(8'h03, 6, 8'hA0, 3);
    issue(8'h03, 1'b1, 6);
    wait_idle(n);
    chk("t4_underrun_set", 32'(wr_underrun), 32'd1);
    chk("t4_wr_ready_count", 32'(wr_cnt), 32'd6);
    $display("txn write cmd=03 len=6 underrun slot 3");

    // 5: command-only cmd 5
    wr_cnt = 0;
    exp_head(8'h05);
    issue(8'h05, 1'b1, 0);
    @(negedge clk);
    chk("t5_underrun_cleared", 32'(wr_underrun), 32'd0);
    chk("t5_sync_t0", 32'(DATA_SYNC), 32'd1);
    @(negedge clk);
    chk("t5_sync_done", 32'(DATA_SYNC), 32'd0);
    chk("t5_busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("t5_busy_idle", 32'(busy), 32'd0);
    chk("t5_wr_ready_count", 32'(wr_cnt), 32'd0);
    $display("txn cmd-only cmd=05");

    // 6a: abort during T2 of read len 12
    exp_head(8'h06);
    lwr = 1'b1;
    issue(8'h06, 1'b0, 12);
    wait_t1();
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    chk("t6a_busy_done", 32'(busy), 32'd1);
    chk("t6a_sync_done", 32'(DATA_SYNC), 32'd0);
    chk("t6a_oe_done", 32'(dut.bus_oe_q), 32'd0);
    chk("t6a_rd_valid_done", 32'(rd_valid), 32'd0);
    @(negedge clk);
    chk("t6a_busy_idle", 32'(busy), 32'd0);
    chk("t6a_rd_valid_idle", 32'(rd_valid), 32'd0);
    $display("txn read cmd=06 len=12 aborted at T2");

    // 6b: reset during T4 of read len 12; bytes 0 and 1 already presented
    exp_head(8'h0A);
    push_ev(K_RD, 3, rbyte(8'h0A, 0), 1'b0);
    push_ev(K_RD, 4, rbyte(8'h0A, 1), 1'b0);
    lwr = 1'b1;
    issue(8'h0A, 1'b0, 12);
    wait_t1();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6b_busy", 32'(busy), 32'd0);
    chk("t6b_sync", 32'(DATA_SYNC), 32'd0);
    chk("t6b_oe", 32'(dut.bus_oe_q), 32'd0);
    chk("t6b_rd_valid", 32'(rd_valid), 32'd0);
    chk("t6b_cmd_ready", 32'(cmd_ready), 32'd1);
    $display("txn read cmd=0A len=12 reset at T4");

    // 7: write after reset must start with a turnaround
    wr_cnt = 0;
    do_write(8'h07, 2, 8'h55, -1);
    issue(8'h07, 1'b1, 2);
    wait_idle(n);
    chk("t7_cycles_to_idle", 32'(n), 32'd6);
    chk("t7_wr_ready_count", 32'(wr_cnt), 32'd2);
    $display("txn write cmd=07 len=2");

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    chk("feed_empty", 32'(feed_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
